// File: rtl/seg_pkg.sv
// Shared segment codes, converter state type and BCD sizing helper for the
// multiplexed decimal display.
package seg_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} convState_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // ceil(w * 0.302) + 1 decimal digits always hold a w-bit unsigned value.
    function automatic int bcdDigits(input int valueW);
        return (valueW * 302 + 999) / 1000 + 1;
    endfunction

    function automatic logic [6:0] segEncode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// start is accepted only while idle; done is high for the single DONE cycle.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VALUE_W = 8,
    parameter int BCD_N   = bcdDigits(VALUE_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VALUE_W-1:0]   bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_N*4-1:0]   bcd
);

    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

    convState_e state, nextState;
    logic [CNT_W-1:0]   bitCnt;
    logic [VALUE_W-1:0] binSr;
    logic [BCD_N*4-1:0] bcdSr;
    logic [BCD_N*4-1:0] bcdAdj;
    logic               loadEn;
    logic               shiftEn;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b1;
        done      = 1'b0;
        loadEn    = 1'b0;
        shiftEn   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    loadEn    = 1'b1;
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                shiftEn = 1'b1;
                if (bitCnt == CNT_LAST) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt <= '0;
        end else if (loadEn) begin
            bitCnt <= '0;
        end else if (shiftEn) begin
            bitCnt <= bitCnt + CNT_W'(1);
        end
    end

    // Adjust every digit before the shift so each one stays a legal BCD digit.
    always_comb begin
        bcdAdj = '0;
        for (int i = 0; i < BCD_N; i++) begin
            bcdAdj[i*4 +: 4] = add3(bcdSr[i*4 +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (loadEn) begin
            binSr <= bin;
            bcdSr <= '0;
        end else if (shiftEn) begin
            bcdSr <= {bcdAdj[BCD_N*4-2:0], binSr[VALUE_W-1]};
            binSr <= {binSr[VALUE_W-2:0], 1'b0};
        end
    end

    assign bcd = bcdSr;

endmodule

// File: rtl/seg_scan_bcd.sv
// Multiplexed seven-segment decimal display with a background BCD converter.
// Define SEG_LZB_EN to blank leading zeros (digit 0 always shows a numeral).
module seg_scan_bcd
    import seg_pkg::*;
#(
    parameter int DIVIDE_BY = 100000,
    parameter int DIGITS    = 4,
    parameter int VALUE_W   = 8
) (
    input  logic               clk,
    input  logic               btnC,
    input  logic [VALUE_W-1:0] value,
    output logic [DIGITS-1:0]  an,
    output logic [6:0]         seg,
    output logic               bcd_valid,
    output logic               ovf
);

    localparam int BCD_N = bcdDigits(VALUE_W);
    localparam int EXT_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
    localparam int REF_W = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(DIVIDE_BY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                 rst;
    logic [REF_W-1:0]     refCnt;
    logic [IDX_W-1:0]     digitIdx;
    logic [VALUE_W-1:0]   shadow;
    logic                 forceCap;
    logic                 convStart;
    logic                 convBusy;
    logic                 convDone;
    logic                 accept;
    logic [BCD_N*4-1:0]   convBcd;
    logic [EXT_N*4-1:0]   bcdExt;
    logic [DIGITS*4-1:0]  dispDigits;
    logic                 dispOvf;
    logic [3:0]           curDigit;

    assign rst = btnC;

    // Any nonzero digit the display cannot show means the value does not fit.
    function automatic logic exceedsDigits(input logic [EXT_N*4-1:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = DIGITS; i < EXT_N; i++) begin
            if (b[i*4 +: 4] != 4'd0) hit = 1'b1;
        end
        return hit;
    endfunction

    // Capture stage: start on a changed input or once right after reset
    assign convStart = forceCap || (value != shadow);
    assign accept    = convStart && !convBusy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            forceCap <= 1'b1;
        end else if (accept) begin
            forceCap <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shadow <= value;
        end
    end

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .BCD_N   (BCD_N)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (convStart),
        .bin   (value),
        .busy  (convBusy),
        .done  (convDone),
        .bcd   (convBcd)
    );

    always_comb begin
        bcdExt = '0;
        bcdExt[BCD_N*4-1:0] = convBcd;
    end

    // Display stage: whole result swapped in at once so no digit is ever stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dispDigits <= '0;
            dispOvf    <= 1'b0;
            bcd_valid  <= 1'b0;
        end else begin
            bcd_valid <= convDone;
            if (convDone) begin
                dispDigits <= bcdExt[DIGITS*4-1:0];
                dispOvf    <= exceedsDigits(bcdExt);
            end
        end
    end

    assign ovf = dispOvf;

    // Scan stage: free-running, never disturbed by conversions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refCnt   <= '0;
            digitIdx <= '0;
        end else if (refCnt == REF_LAST) begin
            refCnt   <= '0;
            digitIdx <= (digitIdx == IDX_LAST) ? '0 : digitIdx + IDX_W'(1);
        end else begin
            refCnt <= refCnt + REF_W'(1);
        end
    end

    assign an = ~(DIGITS'(1) << digitIdx);

    always_comb begin
        curDigit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digitIdx == IDX_W'(i)) curDigit = dispDigits[i*4 +: 4];
        end
    end

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] blankMask;
    logic              seenNonZero;
    logic              curBlank;

    // Walk down from the top digit; everything above the first nonzero blanks.
    always_comb begin
        blankMask   = '0;
        seenNonZero = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (dispDigits[i*4 +: 4] != 4'd0) seenNonZero = 1'b1;
            blankMask[i] = ~seenNonZero;
        end
    end

    always_comb begin
        curBlank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digitIdx == IDX_W'(i)) curBlank = blankMask[i];
        end
    end

    always_comb begin
        if (dispOvf) begin
            seg = SEG_DASH;
        end else if (curBlank) begin
            seg = SEG_BLANK;
        end else begin
            seg = segEncode(curDigit);
        end
    end
`else
    always_comb begin
        if (dispOvf) begin
            seg = SEG_DASH;
        end else begin
            seg = segEncode(curDigit);
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Scoreboard bench for seg_scan_bcd: three instances cover the 8-bit display,
// the 16-bit overflow case and the DIVIDE_BY=1 eight-digit scan.
`timescale 1ns/1ps
module tb_seg_scan_bcd;

    typedef struct packed {
        logic        ovf;
        logic [27:0] segs;   // digit 0 in [6:0]
    } exp_t;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S5 = 7'h12, S7 = 7'h78;
    localparam logic [6:0] S9 = 7'h10, SD = 7'h3F;
`ifdef SEG_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;
    logic [7:0]  valueA = 8'd0;
    logic [15:0] valueB = 16'd0;
    logic [7:0]  valueC = 8'd0;
    logic [3:0]  anA, anB;
    logic [7:0]  anC;
    logic [6:0]  segA, segB, segC;
    logic        bcdValidA, bcdValidB, bcdValidC;
    logic        ovfA, ovfB, ovfC;

    exp_t qA[$];
    exp_t qB[$];
    bit   monBusyA = 1'b0, monBusyB = 1'b0;
    int   nChecks = 0, nFail = 0;

    seg_scan_bcd #(.DIVIDE_BY(2), .DIGITS(4), .VALUE_W(8)) dutA (
        .clk(clk), .btnC(rstA), .value(valueA), .an(anA), .seg(segA),
        .bcd_valid(bcdValidA), .ovf(ovfA));

    seg_scan_bcd #(.DIVIDE_BY(2), .DIGITS(4), .VALUE_W(16)) dutB (
        .clk(clk), .btnC(rstB), .value(valueB), .an(anB), .seg(segB),
        .bcd_valid(bcdValidB), .ovf(ovfB));

    seg_scan_bcd #(.DIVIDE_BY(1), .DIGITS(8), .VALUE_W(8)) dutC (
        .clk(clk), .btnC(rstC), .value(valueC), .an(anC), .seg(segC),
        .bcd_valid(bcdValidC), .ovf(ovfC));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic exp_t mkExp(input logic o, input logic [6:0] d3, input logic [6:0] d2,
                                   input logic [6:0] d1, input logic [6:0] d0);
        exp_t e;
        e.ovf  = o;
        e.segs = {d3, d2, d1, d0};
        return e;
    endfunction

    task automatic sampleDigit(input string tag, input logic [3:0] an, input logic [6:0] seg,
                               input logic [27:0] segs);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (an == ~(4'b0001 << i)) idx = i;
        end
        if (idx < 0) begin
            nChecks++;
            nFail++;
            $display("FAIL %s an: got %b, expected exactly one low bit", tag, an);
        end else begin
            check($sformatf("%s seg[%0d]", tag, idx), seg, segs[idx*7 +: 7]);
        end
    endtask

    task automatic waitIdle(input bit useB, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (useB ? (qB.size() == 0 && !monBusyB) : (qA.size() == 0 && !monBusyA)) return;
        end
        nChecks++;
        nFail++;
        $display("FAIL %s drain: got %0d results pending, expected 0", useB ? "B" : "A",
                 useB ? qB.size() : qA.size());
    endtask

    // Frame right after reset release: zero display, scan E,D,B,7 two cycles each.
    task automatic checkClearedFrameA(input string tag);
        logic [3:0] wantAn;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            wantAn = ~(4'b0001 << (i / 2));
            check({tag, " an"}, anA, wantAn);
            check({tag, " seg"}, segA, (i < 2) ? S0 : LZ);
        end
    endtask

    task automatic checkInReset(input string tag);
        check({tag, " an"}, anA, 4'hE);
        check({tag, " seg"}, segA, S0);
        check({tag, " bcd_valid"}, bcdValidA, 1'b0);
        check({tag, " ovf"}, ovfA, 1'b0);
    endtask

    initial begin : monA
        exp_t e;
        forever begin
            @(negedge clk);
            if (bcdValidA === 1'b1) begin
                if (qA.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL A bcd_valid: got pulse, expected none");
                end else begin
                    monBusyA = 1'b1;
                    e = qA.pop_front();
                    check("A ovf", ovfA, e.ovf);
                    for (int s = 0; s < 8; s++) begin
                        if (s > 0) @(negedge clk);
                        sampleDigit("A frame", anA, segA, e.segs);
                    end
                    monBusyA = 1'b0;
                end
            end
        end
    end

    initial begin : monB
        exp_t e;
        forever begin
            @(negedge clk);
            if (bcdValidB === 1'b1) begin
                if (qB.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL B bcd_valid: got pulse, expected none");
                end else begin
                    monBusyB = 1'b1;
                    e = qB.pop_front();
                    check("B ovf", ovfB, e.ovf);
                    for (int s = 0; s < 8; s++) begin
                        if (s > 0) @(negedge clk);
                        sampleDigit("B frame", anB, segB, e.segs);
                    end
                    monBusyB = 1'b0;
                end
            end
        end
    end

    task automatic stimA();
        int c;
        repeat (3) @(negedge clk);
        #1;
        checkInReset("A reset");
        @(negedge clk);
        rstA = 1'b0;
        qA.push_back(mkExp(1'b0, LZ, LZ, LZ, S0));
        checkClearedFrameA("A first frame");
        waitIdle(1'b0, 60);

        // 0 -> 19: pulse appears on the 10th falling edge (capture edge + 9)
        @(negedge clk);
        valueA = 8'h13;
        qA.push_back(mkExp(1'b0, LZ, LZ, S1, S9));
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (bcdValidA === 1'b1) break;
        end
        check("A latency", c, 10);
        waitIdle(1'b0, 60);

        // value moves while shifting: old value first, then automatic rerun
        @(negedge clk);
        valueA = 8'd5;
        qA.push_back(mkExp(1'b0, LZ, LZ, LZ, S5));
        qA.push_back(mkExp(1'b0, LZ, LZ, LZ, S7));
        repeat (3) @(negedge clk);
        valueA = 8'd7;
        waitIdle(1'b0, 80);

        // reset in the middle of a conversion: nothing partial may surface
        @(negedge clk);
        valueA = 8'd99;
        repeat (4) @(negedge clk);
        rstA = 1'b1;
        #1;
        checkInReset("A mid-shift reset");
        repeat (2) @(negedge clk);
        rstA = 1'b0;
        qA.push_back(mkExp(1'b0, LZ, LZ, S9, S9));
        checkClearedFrameA("A post-reset frame");
        waitIdle(1'b0, 60);
    endtask

    task automatic stimB();
        repeat (4) @(negedge clk);
        rstB = 1'b0;
        qB.push_back(mkExp(1'b0, LZ, LZ, LZ, S0));
        waitIdle(1'b1, 80);
        @(negedge clk);
        valueB = 16'd12345;
        qB.push_back(mkExp(1'b1, SD, SD, SD, SD));
        waitIdle(1'b1, 80);
        @(negedge clk);
        valueB = 16'd9999;
        qB.push_back(mkExp(1'b0, S9, S9, S9, S9));
        waitIdle(1'b1, 80);
    endtask

    task automatic stimC();
        logic [7:0] wantAn;
        repeat (4) @(negedge clk);
        rstC = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            wantAn = ~(8'b0000_0001 << (i % 8));
            check("C an", anC, wantAn);
        end
    endtask

    initial begin
        fork
            stimA();
            stimB();
            stimC();
        join
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

endmodule
